vram_text_fetch: RTL and testbench

//  Video-side text-mode fetch engine driving the read-only video port of the dual-port VRAM.
//  On each line_start it walks one text row: reads the character byte and the colour byte per column.
//  It pushes {col, char, color} into a small output FIFO that the pixel renderer drains with a valid/ready handshake.

---
 rtl/video_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/vram_text_fetch.sv | 185 ++++++++++++++++++
 tb/tb_vram_text_fetch.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the text-mode fetch engine: FSM encoding, default geometry and VRAM map.
// Also holds the cell address helper shared by the character and colour reads.
package video_pkg;

  localparam int          DEF_COLS       = 40;
  localparam int          DEF_ROWS       = 25;
  localparam logic [13:0] DEF_TEXT_BASE  = 14'h3000;
  localparam logic [13:0] DEF_COLOR_BASE = 14'h3400;
  localparam int          ENTRY_W        = 22;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_CHAR  = 2'd1,
    ST_RD_COLOR = 2'd2,
    ST_DRAIN    = 2'd3
  } fetch_state_e;

  // Row-major cell address; the sum wraps modulo 2^14.
  function automatic logic [13:0] cell_addr(input logic [13:0] base, input logic [4:0] row,
                                            input logic [5:0] fcol, input int cols);
    return base + 14'(row) * 14'(cols) + 14'(fcol);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for {col, char, color} entries with flush, count, full and empty.
// A push while full is accepted only when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 22
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/vram_text_fetch.sv
// Text-row fetch engine: reads char and colour bytes per column from VRAM into an output FIFO.
// Optional VRAM_FETCH_HSCROLL_EN adds a horizontal scroll input sampled at line_start.
module vram_text_fetch
  import video_pkg::*;
#(
  parameter int          COLS       = DEF_COLS,
  parameter int          ROWS       = DEF_ROWS,
  parameter logic [13:0] TEXT_BASE  = DEF_TEXT_BASE,
  parameter logic [13:0] COLOR_BASE = DEF_COLOR_BASE,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [7:0]  line_idx,
`ifdef VRAM_FETCH_HSCROLL_EN
  input  logic [5:0]  hscroll,
`endif
  output logic [13:0] vram_addr,
  input  logic [7:0]  vram_rddata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_col,
  output logic [7:0]  out_char,
  output logic [7:0]  out_color,
  output logic        busy,
  output logic        overrun,
  output logic [1:0]  dbg_state
);

  // Handshake: the head entry transfers in any cycle where out_valid && out_ready are both
  // high at the clock edge; while out_valid && !out_ready the head fields hold steady.

  fetch_state_e state_q, state_d;
  logic [4:0]   row_q, row_d;
  logic [5:0]   col_q, col_d;
  logic [5:0]   fcol_q, fcol_d;
  logic [13:0]  addr_q, addr_d;
  logic [7:0]   char_q, char_d;
  logic         push_q, push_d;
  logic [5:0]   push_col_q, push_col_d;
  logic         overrun_q, overrun_d;

  logic                          flush;
  logic                          fifo_push, fifo_pop;
  logic [ENTRY_W-1:0]            fifo_wdata, fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          fifo_full, fifo_empty;

  logic [4:0] row_in;
  logic       row_ok;
  logic [5:0] start_fcol;
  logic [5:0] fcol_inc;
  logic       gate_ok;
  logic       unused_bits;

  assign row_in      = line_idx[7:3];
  assign row_ok      = int'(row_in) < ROWS;
  assign unused_bits = ^line_idx[2:0];
`ifdef VRAM_FETCH_HSCROLL_EN
  assign start_fcol  = 6'(int'(hscroll) % COLS);
`else
  assign start_fcol  = 6'd0;
`endif
  assign fcol_inc    = (fcol_q == 6'(COLS - 1)) ? 6'd0 : fcol_q + 6'd1;
  // The entry pushed this cycle still occupies a slot, so it counts against free space.
  assign gate_ok     = !fifo_full && ((int'(fifo_count) + int'(push_q)) < FIFO_DEPTH);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    fcol_d     = fcol_q;
    addr_d     = addr_q;
    char_d     = char_q;
    push_d     = 1'b0;
    push_col_d = push_col_q;
    overrun_d  = 1'b0;
    flush      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (line_start && row_ok) begin
          row_d   = row_in;
          col_d   = 6'd0;
          fcol_d  = start_fcol;
          addr_d  = cell_addr(TEXT_BASE, row_in, start_fcol, COLS);
          state_d = ST_RD_CHAR;
        end
      end
      ST_RD_CHAR: begin
        if (gate_ok) begin
          addr_d  = cell_addr(COLOR_BASE, row_q, fcol_q, COLS);
          state_d = ST_RD_COLOR;
        end
      end
      ST_RD_COLOR: begin
        char_d     = vram_rddata;
        push_d     = 1'b1;
        push_col_d = col_q;
        if (col_q == 6'(COLS - 1)) begin
          state_d = ST_DRAIN;
        end else begin
          col_d   = col_q + 6'd1;
          fcol_d  = fcol_inc;
          addr_d  = cell_addr(TEXT_BASE, row_q, fcol_inc, COLS);
          state_d = ST_RD_CHAR;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !push_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A new line while busy wins over whatever the FSM was doing.
    if (line_start && state_q != ST_IDLE) begin
      overrun_d = 1'b1;
      flush     = 1'b1;
      push_d    = 1'b0;
      if (row_ok) begin
        row_d   = row_in;
        col_d   = 6'd0;
        fcol_d  = start_fcol;
        addr_d  = cell_addr(TEXT_BASE, row_in, start_fcol, COLS);
        state_d = ST_RD_CHAR;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      fcol_q     <= '0;
      addr_q     <= '0;
      char_q     <= '0;
      push_q     <= 1'b0;
      push_col_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      fcol_q     <= fcol_d;
      addr_q     <= addr_d;
      char_q     <= char_d;
      push_q     <= push_d;
      push_col_q <= push_col_d;
      overrun_q  <= overrun_d;
    end
  end

  // The colour byte arrives the cycle after RD_COLOR and is written straight into the FIFO.
  assign fifo_push  = push_q & ~flush;
  assign fifo_wdata = {push_col_q, char_q, vram_rddata};
  assign fifo_pop   = out_valid & out_ready;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign vram_addr = addr_q;
  assign out_valid = ~fifo_empty;
  assign out_col   = fifo_empty ? 6'd0 : fifo_rdata[21:16];
  assign out_char  = fifo_empty ? 8'd0 : fifo_rdata[15:8];
  assign out_color = fifo_empty ? 8'd0 : fifo_rdata[7:0];
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vram_text_fetch.sv
// Directed bench for vram_text_fetch with a 16K VRAM model (1-cycle read latency).
// Build with VRAM_FETCH_HSCROLL_EN to include the horizontal-scroll steps.
module tb_vram_text_fetch;
  import video_pkg::*;

  localparam int COLS = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [7:0]  line_idx;
  logic [13:0] vram_addr;
  logic [7:0]  vram_rddata;
  logic        out_valid, out_ready;
  logic [5:0]  out_col;
  logic [7:0]  out_char, out_color;
  logic        busy, overrun;
  logic [1:0]  dbg_state;
`ifdef VRAM_FETCH_HSCROLL_EN
  logic [5:0]  hscroll;
`endif

  logic [7:0]  vram [16384];
  logic [21:0] got_q[$];
  logic [21:0] exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  int          start_cyc;
  int          last_pop_cyc = 0;
  int          busy_fall_cyc = 0;
  logic        busy_prev = 1'b0;

  vram_text_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .line_start  (line_start),
    .line_idx    (line_idx),
`ifdef VRAM_FETCH_HSCROLL_EN
    .hscroll     (hscroll),
`endif
    .vram_addr   (vram_addr),
    .vram_rddata (vram_rddata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_col     (out_col),
    .out_char    (out_char),
    .out_color   (out_color),
    .busy        (busy),
    .overrun     (overrun),
    .dbg_state   (dbg_state)
  );

  // Clock, cycle counter and VRAM model
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) vram_rddata <= vram[vram_addr];

  // Output monitor: records every accepted entry, plus timing of the last pop and of busy falling
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      got_q.push_back({out_col, out_char, out_color});
      last_pop_cyc = cyc;
    end
    if (busy_prev && !busy) busy_fall_cyc = cyc;
    busy_prev = busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle line_start; returns in the cycle after the sampling edge.
  task automatic pulse(input logic [7:0] idx);
    line_start = 1'b1;
    line_idx   = idx;
    @(posedge clk);
    #1;
    line_start = 1'b0;
    start_cyc  = cyc;
  endtask

  // Expected row contents: char at text[row*COLS+fc] = low byte of offset, colour is its inverse.
  task automatic compare_row(input string tag, input int row, input int scroll);
    int fc;
    logic [7:0] ch;
    exp_q.delete();
    for (int c = 0; c < COLS; c++) begin
      fc = (c + scroll) % COLS;
      ch = 8'(row * COLS + fc);
      exp_q.push_back({6'(c), ch, ~ch});
    end
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < COLS && i < got_q.size(); i++)
      check($sformatf("%s_entry%0d", tag, i), {10'd0, got_q[i]}, {10'd0, exp_q[i]});
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      vram[14'h3000 + i] = 8'(i);
      vram[14'h3400 + i] = ~8'(i);
    end
    reset      = 1'b1;
    line_start = 1'b0;
    line_idx   = 8'd0;
    out_ready  = 1'b1;
`ifdef VRAM_FETCH_HSCROLL_EN
    hscroll    = 6'd0;
`endif

    // Reset state
    tick(3);
    check("rst_valid", out_valid, 1'b0);
    check("rst_addr", vram_addr, 14'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_head", {out_col, out_char, out_color}, 22'd0);
    check("rst_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    tick(1);

    // Row 0, no backpressure: column k lands in the FIFO on edge 2k+3 after the line_start
    // edge and is accepted one edge later, so the last pop is seen 2*COLS+1 cycles in and
    // busy drops once the FIFO has drained.
    got_q.delete();
    pulse(8'd0);
    check("row0_busy", busy, 1'b1);
    tick(95);
    check("row0_last_pop_cyc", last_pop_cyc - start_cyc, 2 * COLS + 1);
    check("row0_busy_fall_cyc", busy_fall_cyc - start_cyc, 2 * COLS + 3);
    check("row0_idle", dbg_state, ST_IDLE);
    compare_row("row0", 0, 0);

    // Row 2 (line_idx 17): address sequence and contents
    got_q.delete();
    pulse(8'd17);
    check("row2_addr_c0_char", vram_addr, 14'h3050);
    tick(1);
    check("row2_addr_c0_color", vram_addr, 14'h3450);
    tick(1);
    check("row2_addr_c1_char", vram_addr, 14'h3051);
    tick(90);
    compare_row("row2", 2, 0);

    // line_idx 200 is row 25: ignored, address stays on the last colour read
    got_q.delete();
    pulse(8'd200);
    check("row25_busy", busy, 1'b0);
    check("row25_addr", vram_addr, 14'h3477);
    check("row25_state", dbg_state, ST_IDLE);
    tick(10);
    check("row25_no_entries", got_q.size(), 0);
    check("row25_overrun", overrun, 1'b0);

    // Backpressure: ready low from edge 10 fills the FIFO with cols 4..7, col 8 waits in RD_CHAR
    got_q.delete();
    pulse(8'd0);
    tick(10);
    out_ready = 1'b0;
    tick(10);
    check("stall_count", dut.fifo_count, 4);
    check("stall_addr_a", vram_addr, 14'h3008);
    check("stall_valid", out_valid, 1'b1);
    check("stall_head_a", {out_col, out_char, out_color}, {6'd4, 8'h04, 8'hFB});
    tick(9);
    check("stall_addr_b", vram_addr, 14'h3008);
    check("stall_head_b", {out_col, out_char, out_color}, {6'd4, 8'h04, 8'hFB});
    tick(1);
    out_ready = 1'b1;
    tick(100);
    compare_row("stall", 0, 0);

    // Overrun: new line_start (row 1) on edge 30 of a row-0 fetch
    got_q.delete();
    pulse(8'd0);
    tick(29);
    line_start = 1'b1;
    line_idx   = 8'd8;
    tick(1);
    line_start = 1'b0;
    got_q.delete();
    check("ovr_pulse", overrun, 1'b1);
    check("ovr_flushed", out_valid, 1'b0);
    check("ovr_restart_addr", vram_addr, 14'h3028);
    check("ovr_busy", busy, 1'b1);
    tick(1);
    check("ovr_pulse_end", overrun, 1'b0);
    tick(100);
    compare_row("ovr_row1", 1, 0);

    // Reset on edge 15 of a fetch, then a normal row 3 fetch
    got_q.delete();
    pulse(8'd0);
    tick(14);
    reset = 1'b1;
    tick(1);
    check("mrst_valid", out_valid, 1'b0);
    check("mrst_head", {out_col, out_char, out_color}, 22'd0);
    check("mrst_addr", vram_addr, 14'h0000);
    check("mrst_busy", busy, 1'b0);
    check("mrst_overrun", overrun, 1'b0);
    check("mrst_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    tick(1);
    got_q.delete();
    pulse(8'd24);
    tick(100);
    compare_row("mrst_row3", 3, 0);

`ifdef VRAM_FETCH_HSCROLL_EN
    // Horizontal scroll wraps within the row; out_col stays the screen column
    got_q.delete();
    hscroll = 6'd38;
    pulse(8'd0);
    tick(100);
    compare_row("hs38", 0, 38);
    got_q.delete();
    hscroll = 6'd45;
    pulse(8'd8);
    tick(100);
    compare_row("hs45", 1, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
